// File: rtl/rv32_scoreboard_issue_stage_pkg.sv
// Shared types for the rv32 issue stage: buffered instruction entry, NOP encoding
// and register-index width.
package rv32_types;

  localparam int ENTRY_NUM_RS   = 3;
  localparam int ENTRY_NUM_REGS = 32;
  localparam int REG_IDX_W      = $clog2(ENTRY_NUM_REGS);

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]                                pc;
    logic [31:0]                                instr;
    logic [ENTRY_NUM_RS-1:0][REG_IDX_W-1:0]     rs;
    logic [ENTRY_NUM_RS-1:0]                    use_rs;
    logic [REG_IDX_W-1:0]                       rd;
    logic                                       wr_rd;
  } issue_entry_t;

endpackage

// File: rtl/rv32_scoreboard_issue_stage_fifo.sv
// Small circular instruction buffer with flush and a registered full flag so that
// ready never depends combinationally on the consumer.
module rv32_issue_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             push_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign push_s  = push_i && !full_q && !flush_i;
  assign pop_s   = pop_i && (count_q != '0) && !flush_i;
  assign ready_o = !full_q;
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer/occupancy next state; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNTW'(push_s) - CNTW'(pop_s);
    end
    full_d = (count_d == CNTW'(DEPTH));
  end

  // Storage and control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/rv32_scoreboard_issue_stage.sv
// In-order issue stage: buffers decoded instructions and issues them once every
// source is free of pending writes, tracked by per-register in-flight counters.
module rv32_scoreboard_issue_stage
  import rv32_types::*;
#(
  parameter int NUM_RS      = ENTRY_NUM_RS,
  parameter int NUM_REGS    = ENTRY_NUM_REGS,
  parameter int MAX_PENDING = 3,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [31:0]                          in_pc,
  input  logic [31:0]                          in_instr,
  input  logic [NUM_RS*$clog2(NUM_REGS)-1:0]   in_rs,
  input  logic [NUM_RS-1:0]                    in_use_rs,
  input  logic [$clog2(NUM_REGS)-1:0]          in_rd,
  input  logic                                 in_wr_rd,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_pc,
  output logic [31:0]                          out_instr,
  output logic [$clog2(NUM_REGS)-1:0]          out_rd,
  output logic                                 out_wr_rd,
  input  logic                                 wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]          wb_rd,
  output logic                                 hazard_stall,
  output logic                                 sb_err
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int EW = $bits(issue_entry_t);

  issue_entry_t   in_entry_s, head_s;
  logic [EW-1:0]  head_bits_s;
  logic           head_valid_s, raw_hit_s, waw_full_s, hazard_s, issue_fire_s, kill_s;
  logic [CW:0]    step_s;

  logic [CW-1:0]  cnt_q [NUM_REGS];
  logic [CW-1:0]  cnt_d [NUM_REGS];
  logic           sb_err_q, sb_err_d;
  logic           out_valid_q, out_valid_d, out_wr_rd_q, out_wr_rd_d;
  logic [31:0]    out_pc_q, out_pc_d, out_instr_q, out_instr_d;
  logic [RW-1:0]  out_rd_q, out_rd_d;

  // Returns {underflow, next count}; a decrement below zero clamps at zero.
  function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cur, input logic inc,
                                           input logic [1:0] dec);
    logic [CW:0] sum;
    sum = {1'b0, cur} + (CW+1)'(inc);
    if (sum < (CW+1)'(dec)) begin
      return {1'b1, {CW{1'b0}}};
    end else begin
      return {1'b0, CW'(sum - (CW+1)'(dec))};
    end
  endfunction

  // Pack the offered instruction into a buffer entry.
  always_comb begin
    in_entry_s        = '0;
    in_entry_s.pc     = in_pc;
    in_entry_s.instr  = in_instr;
    in_entry_s.rs     = in_rs;
    in_entry_s.use_rs = in_use_rs;
    in_entry_s.rd     = in_rd;
    in_entry_s.wr_rd  = in_wr_rd;
  end

  rv32_issue_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (in_valid),
    .data_i  (in_entry_s),
    .ready_o (in_ready),
    .pop_i   (issue_fire_s),
    .valid_o (head_valid_s),
    .data_o  (head_bits_s)
  );

  assign head_s = issue_entry_t'(head_bits_s);

  // RAW on any used non-x0 source with a pending write; WAW only when the counter is saturated.
  always_comb begin
    raw_hit_s = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      raw_hit_s = raw_hit_s | (head_s.use_rs[i] && (head_s.rs[i] != '0) &&
                               (cnt_q[head_s.rs[i]] != '0));
    end
    waw_full_s = head_s.wr_rd && (head_s.rd != '0) && (cnt_q[head_s.rd] == CW'(MAX_PENDING));
  end

  assign hazard_s     = head_valid_s && (raw_hit_s || waw_full_s);
  assign issue_fire_s = head_valid_s && !hazard_s && (!out_valid_q || out_ready) && !flush;
  assign kill_s       = flush && out_valid_q && out_wr_rd_q;
  assign hazard_stall = hazard_s;

  // Per-register net delta: issue increments, retire and flush-kill decrement.
  always_comb begin
    sb_err_d = sb_err_q;
    step_s   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      step_s = cnt_step(cnt_q[r],
                        issue_fire_s && head_s.wr_rd && (head_s.rd == RW'(r)),
                        {1'b0, wb_valid && (wb_rd == RW'(r))} +
                        {1'b0, kill_s && (out_rd_q == RW'(r))});
      if (r == 0) begin
        cnt_d[r] = '0;
      end else begin
        cnt_d[r] = step_s[CW-1:0];
        sb_err_d = sb_err_d | step_s[CW];
      end
    end
  end

  // Output register: load on issue, drop on consume or flush, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_rd_d    = out_rd_q;
    out_wr_rd_d = out_wr_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue_fire_s) begin
      out_valid_d = 1'b1;
      out_pc_d    = head_s.pc;
      out_instr_d = head_s.instr;
      out_rd_d    = head_s.rd;
      out_wr_rd_d = head_s.wr_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= RV_NOP;
      out_rd_q    <= '0;
      out_wr_rd_q <= 1'b0;
      sb_err_q    <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_rd_q    <= out_rd_d;
      out_wr_rd_q <= out_wr_rd_d;
      sb_err_q    <= sb_err_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_rd    = out_rd_q;
  assign out_wr_rd = out_wr_rd_q;
  assign sb_err    = sb_err_q;

endmodule
